cpu_ctrl_seq: RTL and testbench

//   Multicycle control sequencer for the 16-bit CPU datapath (16-bit in/out top level).

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/cpu_ctrl_seq.sv | 179 +++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control sequencer:
// state codes, opcode values and the opcode-class decoder.
package cpu_ctrl_pkg;

    localparam int WAIT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_IRQ    = 3'd7
    } state_t;

    localparam logic [3:0] OPC_LD   = 4'h8;
    localparam logic [3:0] OPC_ST   = 4'h9;
    localparam logic [3:0] OPC_BZ   = 4'hA;
    localparam logic [3:0] OPC_JMP  = 4'hB;
    localparam logic [3:0] OPC_NOP  = 4'hE;
    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [2:0] {
        C_ALU, C_LD, C_ST, C_BZ, C_JMP, C_NOP, C_HALT, C_ILL
    } opc_class_t;

    // Opcodes 0x0-0x7 are all ALU operations; 0xC/0xD are unused.
    function automatic opc_class_t decode_class(input logic [3:0] opc);
        opc_class_t cls;
        if (!opc[3]) begin
            cls = C_ALU;
        end else begin
            case (opc)
                OPC_LD:   cls = C_LD;
                OPC_ST:   cls = C_ST;
                OPC_BZ:   cls = C_BZ;
                OPC_JMP:  cls = C_JMP;
                OPC_NOP:  cls = C_NOP;
                OPC_HALT: cls = C_HALT;
                default:  cls = C_ILL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts unanswered request cycles and flags
// when the count reaches the timeout limit.
module mem_wait_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_timeout
);

    localparam logic [WAIT_W-1:0] LP_LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_wait) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (r_count == LP_LIMIT);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with bounded memory waits.
// Optional interrupt entry (irq/irq_ack, IRQ state) when CPU_CTRL_IRQ_EN is defined.
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        zero_flag,
    input  logic        mem_ready,
`ifdef CPU_CTRL_IRQ_EN
    input  logic        irq,
    output logic        irq_ack,
`endif
    output logic        pc_we,
    output logic        pc_sel,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [3:0]  alu_op,
    output logic        flag_we,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t           r_state;
    state_t           w_next_state;
    state_t           w_ret_state;
    opc_class_t       w_class;
    logic [OPC_W-1:0] w_opc;
    logic             w_timeout;
    logic             w_wait_clr;
    logic             w_wait_inc;
    logic             w_unused_instr;

    assign w_opc          = instr[15 -: OPC_W];
    assign w_class        = decode_class(w_opc);
    assign w_unused_instr = ^instr[15-OPC_W:0];
    assign state          = r_state;

    // Every path that would return to FETCH goes through here so irq is sampled in one place.
`ifdef CPU_CTRL_IRQ_EN
    assign w_ret_state = irq ? S_IRQ : S_FETCH;
`else
    assign w_ret_state = S_FETCH;
`endif

    // Any state change clears the count, so FETCH and MEM always start from zero.
    assign w_wait_clr = (w_next_state != r_state);
    assign w_wait_inc = mem_req && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_wait_clr),
        .i_wait    (w_wait_inc),
        .o_timeout (w_timeout)
    );

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves the variable unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next_state = S_FETCH;
            S_FETCH: begin
                if (w_timeout)      w_next_state = S_HALT;
                else if (mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                case (w_class)
                    C_NOP, C_ILL: w_next_state = w_ret_state;
                    C_HALT:       w_next_state = S_HALT;
                    default:      w_next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (w_class == C_LD || w_class == C_ST) w_next_state = S_MEM;
                else                                    w_next_state = w_ret_state;
            end
            S_MEM: begin
                if (w_timeout)      w_next_state = S_HALT;
                else if (mem_ready) w_next_state = (w_class == C_LD) ? S_WB : w_ret_state;
            end
            S_WB:     w_next_state = w_ret_state;
            S_HALT:   w_next_state = S_HALT;
`ifdef CPU_CTRL_IRQ_EN
            S_IRQ:    w_next_state = S_FETCH;
`endif
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        ir_we    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        alu_op   = 4'h0;
        flag_we  = 1'b0;
        halted   = 1'b0;
        bus_err  = 1'b0;
        illegal  = 1'b0;
`ifdef CPU_CTRL_IRQ_EN
        irq_ack  = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                // Timeout takes priority: the request drops and any late ready is ignored.
                mem_req = !w_timeout;
                bus_err = w_timeout;
                ir_we   = !w_timeout && mem_ready;
                pc_we   = !w_timeout && mem_ready;
            end
            S_DECODE: illegal = (w_class == C_ILL);
            S_EXEC: begin
                case (w_class)
                    C_ALU: begin
                        alu_op  = w_opc;
                        rf_we   = 1'b1;
                        flag_we = 1'b1;
                    end
                    C_BZ: begin
                        pc_we  = zero_flag;
                        pc_sel = 1'b1;
                    end
                    C_JMP: begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = !w_timeout;
                mem_we   = !w_timeout && (w_class == C_ST);
                addr_sel = 1'b1;
                bus_err  = w_timeout;
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wsel = 1'b1;
            end
            S_HALT:   halted = 1'b1;
`ifdef CPU_CTRL_IRQ_EN
            S_IRQ: begin
                irq_ack = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: per-instruction expected cycle traces
// built from the instruction-level timing rules, with randomized traffic.
module tb_cpu_ctrl_seq;

    localparam int TMO = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic       pc_sel;
        logic       ir_we;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       rf_we;
        logic       rf_wsel;
        logic [3:0] alu_op;
        logic       flag_we;
        logic       halted;
        logic       bus_err;
        logic       illegal;
    } obs_t;

    // rdy: mem_ready to drive; free: mem_ready must be ignored, so drive it randomly.
    typedef struct packed {
        logic rdy;
        logic free;
        obs_t o;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_we, pc_sel, ir_we, mem_req, mem_we, addr_sel, rf_we, rf_wsel;
    logic [3:0]  alu_op;
    logic        flag_we, halted, bus_err, illegal;
    logic [2:0]  state;

    int   checks = 0;
    int   failures = 0;
    cyc_t trace[$];

    cpu_ctrl_seq #(.OPC_W(4), .MEM_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .instr     (instr),
        .zero_flag (zero_flag),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .ir_we     (ir_we),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .alu_op    (alu_op),
        .flag_we   (flag_we),
        .halted    (halted),
        .bus_err   (bus_err),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        return {state, pc_we, pc_sel, ir_we, mem_req, mem_we, addr_sel,
                rf_we, rf_wsel, alu_op, flag_we, halted, bus_err, illegal};
    endfunction

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    task automatic add(input obs_t o, input logic rdy, input logic free);
        cyc_t c;
        c.rdy  = rdy;
        c.free = free;
        c.o    = o;
        trace.push_back(c);
    endtask

    task automatic add_bus_err(input logic [2:0] st);
        obs_t o;
        o = mk(st);
        o.bus_err = 1'b1;
        add(o, 1'b0, 1'b1);
        o = mk(3'd6);
        o.halted = 1'b1;
        for (int i = 0; i < 4; i++) add(o, 1'b0, 1'b1);
    endtask

    // Expected cycle sequence of one instruction, from its FETCH up to (not
    // including) the next FETCH. fw/mw = unanswered cycles before mem_ready.
    task automatic build(input logic [3:0] opc, input logic zf, input int fw, input int mw);
        obs_t o;
        trace.delete();
        for (int i = 0; i < fw && i < TMO; i++) begin
            o = mk(3'd1); o.mem_req = 1'b1; add(o, 1'b0, 1'b0);
        end
        if (fw >= TMO) begin add_bus_err(3'd1); return; end
        o = mk(3'd1); o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
        add(o, 1'b1, 1'b0);
        o = mk(3'd2); o.illegal = (opc == 4'hC || opc == 4'hD);
        add(o, 1'b0, 1'b1);
        if (opc == 4'hF) begin
            o = mk(3'd6); o.halted = 1'b1;
            for (int i = 0; i < 5; i++) add(o, 1'b0, 1'b1);
            return;
        end
        if (opc >= 4'hC) return;
        o = mk(3'd3);
        if (opc < 4'h8) begin
            o.alu_op = opc; o.rf_we = 1'b1; o.flag_we = 1'b1;
        end else if (opc == 4'hA) begin
            o.pc_we = zf; o.pc_sel = 1'b1;
        end else if (opc == 4'hB) begin
            o.pc_we = 1'b1; o.pc_sel = 1'b1;
        end
        add(o, 1'b0, 1'b1);
        if (opc != 4'h8 && opc != 4'h9) return;
        for (int i = 0; i < mw && i < TMO; i++) begin
            o = mk(3'd4); o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (opc == 4'h9);
            add(o, 1'b0, 1'b0);
        end
        if (mw >= TMO) begin
            o = mk(3'd4); o.addr_sel = 1'b1; o.bus_err = 1'b1;
            add(o, 1'b0, 1'b1);
            o = mk(3'd6); o.halted = 1'b1;
            for (int i = 0; i < 4; i++) add(o, 1'b0, 1'b1);
            return;
        end
        o = mk(3'd4); o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (opc == 4'h9);
        add(o, 1'b1, 1'b0);
        if (opc == 4'h9) return;
        o = mk(3'd5); o.rf_we = 1'b1; o.rf_wsel = 1'b1;
        add(o, 1'b0, 1'b1);
    endtask

    // Called at posedge+1; run is randomized every cycle since it only matters in IDLE.
    task automatic play(input string name, input logic [15:0] ins, input logic zf);
        obs_t got;
        instr = ins;
        zero_flag = zf;
        foreach (trace[i]) begin
            mem_ready = trace[i].free ? 1'($urandom) : trace[i].rdy;
            run = 1'($urandom);
            #2;
            got = observe();
            checks++;
            if (got !== trace[i].o) begin
                failures++;
                $display("FAIL %s instr=%h cycle %0d: got %h expected %h",
                         name, ins, i, got, trace[i].o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic restart();
        obs_t got;
        rst = 1'b1; run = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL restart_idle: got %h expected %h", got, obs_t'('0));
        end
        rst = 1'b0; run = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            got = observe();
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL reset_cycle%0d: got %h expected %h", i, got, obs_t'('0));
            end
        end
        rst = 1'b0; run = 1'b0;
        @(posedge clk); #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL idle_run_low: got %h expected %h", got, obs_t'('0));
        end
        run = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        got = observe();
        exp = mk(3'd1);
        exp.mem_req = 1'b1;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL idle_to_fetch: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_alu();
        build(4'h3, 1'b0, 0, 0);
        play("alu_zero_wait", 16'h3123, 1'b0);
        build(4'h7, 1'b1, 2, 0);
        play("alu_fetch_wait", 16'h7fff, 1'b1);
    endtask

    task automatic test_load_store();
        build(4'h8, 1'b0, 0, 4);
        play("ld_mem_wait4", 16'h8abc, 1'b0);
        build(4'h8, 1'b0, 0, 0);
        play("ld_zero_wait", 16'h8001, 1'b0);
        build(4'h9, 1'b0, 1, 2);
        play("st_wait", 16'h9345, 1'b0);
        build(4'h9, 1'b0, 0, 0);
        play("st_zero_wait", 16'h9000, 1'b0);
    endtask

    task automatic test_branch();
        build(4'hA, 1'b0, 0, 0);
        play("bz_not_taken", 16'hA010, 1'b0);
        build(4'hA, 1'b1, 0, 0);
        play("bz_taken", 16'hA010, 1'b1);
        build(4'hB, 1'b0, 0, 0);
        play("jmp", 16'hB222, 1'b0);
    endtask

    task automatic test_illegal_nop();
        build(4'hC, 1'b0, 0, 0);
        play("illegal_c", 16'hC000, 1'b0);
        build(4'hD, 1'b0, 1, 0);
        play("illegal_d", 16'hD123, 1'b0);
        build(4'hE, 1'b0, 0, 0);
        play("nop", 16'hE000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  opc;
        logic [15:0] ins;
        logic        zf;
        for (int n = 0; n < 40; n++) begin
            opc = 4'($urandom_range(0, 14));
            ins = {opc, 12'($urandom)};
            zf  = 1'($urandom);
            build(opc, zf, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            play("random", ins, zf);
        end
    endtask

    task automatic test_timeout();
        build(4'h1, 1'b0, TMO - 1, 0);
        play("fetch_wait_max", 16'h1000, 1'b0);
        build(4'h8, 1'b0, 0, TMO - 1);
        play("mem_wait_max", 16'h8000, 1'b0);
        build(4'h1, 1'b0, TMO + 5, 0);
        play("fetch_timeout", 16'h1000, 1'b0);
        restart();
        build(4'h8, 1'b0, 0, TMO);
        play("mem_timeout", 16'h8555, 1'b0);
        restart();
    endtask

    task automatic test_halt();
        build(4'hF, 1'b0, 0, 0);
        play("halt", 16'hF000, 1'b0);
        restart();
        build(4'h2, 1'b0, 0, 0);
        play("after_halt", 16'h2000, 1'b0);
        restart();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal_nop();
        test_back_to_back();
        test_timeout();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
